// File: rtl/rob_retire_sched.sv
// rob_retire_sched: in-order retirement scheduler freeing displaced pregs in program order
// Define ROB_PERF_EN to add the perf_retired / perf_stall counters.
module rob_retire_sched #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = $clog2(DEPTH),
    parameter int PREG_W    = 4,
    parameter int PHYS_REGS = 16,
    parameter int ARCH_REGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    input  logic              disp_has_dest,
    input  logic [PREG_W-1:0] disp_oldphys,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_tag,
    input  logic              drain_req,
    output logic              drained,
    output logic [PREG_W:0]   retire_out,
    output logic [PREG_W:0]   free_count
`ifdef ROB_PERF_EN
    ,
    output logic [15:0]       perf_retired,
    output logic [15:0]       perf_stall
`endif
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    localparam logic [PREG_W:0] FC_MAX = (PREG_W+1)'(PHYS_REGS);
    localparam logic [PREG_W:0] FC_RST = (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
    localparam logic [PREG_W:0] FC_ONE = (PREG_W+1)'(1);

    logic [0:0]        state;
    logic [TAG_W:0]    head, tail;
    logic [DEPTH-1:0]  s_valid, s_done, s_dest;
    logic [PREG_W-1:0] s_old [DEPTH];
    logic [TAG_W-1:0]  hidx, tidx;
    logic              empty, full, accept, retire, take, give;

    always_comb begin
        hidx = head[TAG_W-1:0];
        tidx = tail[TAG_W-1:0];
        empty = head == tail;
        full = (hidx == tidx) && (head[TAG_W] != tail[TAG_W]);
        disp_ready = (state == RUN) && !full && (!disp_has_dest || free_count != '0);
        disp_tag = tidx;
        drained = (state == DRAIN) && empty;
        accept = disp_valid && disp_ready;
        retire = s_valid[hidx] && s_done[hidx];
        take = accept && disp_has_dest;
        give = retire && s_dest[hidx];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else if (state == RUN && drain_req)
            state <= DRAIN;
        else if (state == DRAIN && !drain_req && empty)
            state <= RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            retire_out <= '0;
            free_count <= FC_RST;
        end else begin
            head <= head + (TAG_W+1)'(retire);
            tail <= tail + (TAG_W+1)'(accept);
            retire_out <= give ? {s_old[hidx], 1'b1} : '0;
            if (take && !give)
                free_count <= free_count - FC_ONE;
            else if (give && !take && free_count != FC_MAX)
                free_count <= free_count + FC_ONE;
        end
    end

    // Later statements win: a dispatch into a slot overrides any completion aimed at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= '0;
            s_done <= '0;
        end else begin
            if (retire) begin
                s_valid[hidx] <= 1'b0;
                s_done[hidx] <= 1'b0;
            end
            if (cmpl_valid && s_valid[cmpl_tag] && !s_done[cmpl_tag])
                s_done[cmpl_tag] <= 1'b1;
            if (accept) begin
                s_valid[tidx] <= 1'b1;
                s_done[tidx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s_dest[tidx] <= disp_has_dest;
            s_old[tidx] <= disp_oldphys;
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= '0;
            perf_stall <= '0;
        end else begin
            perf_retired <= perf_retired + 16'(retire);
            perf_stall <= perf_stall + 16'(disp_valid && !disp_ready);
        end
    end
`endif
endmodule
